// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator. Produces pixel
//             coordinates and line/frame strobes, and aligns syncs, data
//             enable and blanked RGB on one output register after a
//             programmable pixel-pipeline latency.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 29,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int CW       = 11,
   parameter int RW       = 3,
   parameter int GW       = 3,
   parameter int BW       = 2,
   parameter int PIX_LAT  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic [RW-1:0] rin,
   input  logic [GW-1:0] gin,
   input  logic [BW-1:0] bin,
   output logic [CW-1:0] xpos,
   output logic [CW-1:0] ypos,
   output logic          active,
   output logic          line_start,
   output logic          frame_start,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [RW-1:0] rout,
   output logic [GW-1:0] gout,
   output logic [BW-1:0] bout
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Comparisons are done one bit wider so sync-end bounds equal to the
   // total count never overflow the counter width.
   localparam logic [CW:0]   c_H_ACT  = (CW+1)'(H_ACTIVE);
   localparam logic [CW:0]   c_HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
   localparam logic [CW:0]   c_HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW:0]   c_V_ACT  = (CW+1)'(V_ACTIVE);
   localparam logic [CW:0]   c_VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
   localparam logic [CW:0]   c_VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] c_H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] c_V_LAST = CW'(V_TOTAL - 1);
   localparam logic          c_HPOL   = (H_POL != 0);
   localparam logic          c_VPOL   = (V_POL != 0);

   if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
      $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
   end
   if (PIX_LAT < 0 || PIX_LAT > 4) begin : g_bad_lat
      $error("vga_timing_gen: PIX_LAT must be 0..4");
   end

   logic [CW-1:0] hc_q, hc_d;
   logic [CW-1:0] vc_q, vc_d;
   logic          h_act, v_act, hs_raw, vs_raw;
   logic [2:0]    raw_w;    // {active, hs_raw, vs_raw}
   logic [2:0]    dly_w;

   logic          de_q, hsync_q, vsync_q;
   logic [RW-1:0] r_q;
   logic [GW-1:0] g_q;
   logic [BW-1:0] b_q;

   // Raster counters next state: hc wraps at line end, vc steps on hc wrap.
   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      if (ce) begin
         if (hc_q == c_H_LAST) begin
            hc_d = '0;
            if (vc_q == c_V_LAST) vc_d = '0;
            else                  vc_d = vc_q + 1'b1;
         end else begin
            hc_d = hc_q + 1'b1;
         end
      end
   end

   // Raster counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   // Raw timing decoded straight from the counters.
   always_comb begin
      h_act  = {1'b0, hc_q} < c_H_ACT;
      v_act  = {1'b0, vc_q} < c_V_ACT;
      hs_raw = ({1'b0, hc_q} >= c_HS_BEG) && ({1'b0, hc_q} < c_HS_END);
      vs_raw = ({1'b0, vc_q} >= c_VS_BEG) && ({1'b0, vc_q} < c_VS_END);
      raw_w  = {h_act && v_act, hs_raw, vs_raw};
   end

   // Timing delay line matching the pixel generator latency.
   if (PIX_LAT == 0) begin : g_direct
      assign dly_w = raw_w;
   end else begin : g_pipe
      logic [2:0] pipe_q [PIX_LAT];

      // Shift raw timing one stage per pixel tick; reset fills with inactive.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < PIX_LAT; i++) pipe_q[i] <= 3'b000;
         end else if (ce) begin
            pipe_q[0] <= raw_w;
            for (int i = 1; i < PIX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      assign dly_w = pipe_q[PIX_LAT-1];
   end

   // Output register: syncs at polarity, data enable and blanked colour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_q    <= 1'b0;
         hsync_q <= ~c_HPOL;
         vsync_q <= ~c_VPOL;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else if (ce) begin
         de_q    <= dly_w[2];
         hsync_q <= dly_w[1] ? c_HPOL : ~c_HPOL;
         vsync_q <= dly_w[0] ? c_VPOL : ~c_VPOL;
         r_q     <= dly_w[2] ? rin : '0;
         g_q     <= dly_w[2] ? gin : '0;
         b_q     <= dly_w[2] ? bin : '0;
      end
   end

   assign xpos        = hc_q;
   assign ypos        = vc_q;
   assign active      = h_act && v_act;
   assign line_start  = ce && !rst && (hc_q == '0);
   assign frame_start = ce && !rst && (hc_q == '0) && (vc_q == '0);
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rout        = r_q;
   assign gout        = g_q;
   assign bout        = b_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen using a small raster,
//             mixed sync polarity, PIX_LAT=2, random ce gapping, random
//             pixel colours and an asynchronous mid-run reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
   localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;   // 15
   localparam int VT = VA + VFP + VS + VBP;   // 8
   localparam int FRAME = HT * VT;            // 120 ticks
   localparam int LAT = 2;
   localparam int CW = 5;
   localparam bit HP = 1'b0;
   localparam bit VP = 1'b1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ce  = 1'b0;
   logic [2:0]    rin = '0, gin = '0;
   logic [1:0]    bin = '0;
   logic [CW-1:0] xpos, ypos;
   logic          active, line_start, frame_start, hsync, vsync, de;
   logic [2:0]    rout, gout;
   logic [1:0]    bout;

   int            vectors = 0;
   int            miscompares = 0;
   int            k = 0;                // pixel ticks since reset release
   logic [7:0]    tbl [FRAME];          // colour of each raster position

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .H_POL(32'(HP)), .V_POL(32'(VP)), .CW(CW),
      .RW(3), .GW(3), .BW(2), .PIX_LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce),
      .rin(rin), .gin(gin), .bin(bin),
      .xpos(xpos), .ypos(ypos), .active(active),
      .line_start(line_start), .frame_start(frame_start),
      .hsync(hsync), .vsync(vsync), .de(de),
      .rout(rout), .gout(gout), .bout(bout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, k);
      end
   endtask

   // Registered outputs after k ticks show raster position k-1-LAT.
   task automatic check_regs();
      int         p, x, y;
      logic       e_de, e_hs, e_vs;
      logic [7:0] e_rgb;
      p = k - 1 - LAT;
      if (p < 0) begin
         e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
      end else begin
         x    = p % HT;
         y    = (p / HT) % VT;
         e_de = (x < HA) && (y < VA);
         e_hs = (x >= HA + HFP) && (x < HA + HFP + HS);
         e_vs = (y >= VA + VFP) && (y < VA + VFP + VS);
      end
      e_rgb = e_de ? tbl[(p < 0) ? 0 : (p % FRAME)] : 8'h00;
      chk("de",    32'(de),    32'(e_de));
      chk("hsync", 32'(hsync), 32'(e_hs ? HP : !HP));
      chk("vsync", 32'(vsync), 32'(e_vs ? VP : !VP));
      chk("rgb",   32'({rout, gout, bout}), 32'(e_rgb));
   endtask

   // Undelayed outputs reflect raster position k directly.
   task automatic check_comb(input bit ce_v);
      int x, y;
      x = k % HT;
      y = (k / HT) % VT;
      chk("xpos",        32'(xpos),        32'(x));
      chk("ypos",        32'(ypos),        32'(y));
      chk("active",      32'(active),      32'((x < HA) && (y < VA)));
      chk("line_start",  32'(line_start),  32'(ce_v && x == 0));
      chk("frame_start", 32'(frame_start), 32'(ce_v && x == 0 && y == 0));
   endtask

   // One clk cycle, entered and left at a negative edge.
   task automatic tick(input bit ce_v);
      check_regs();
      ce = ce_v;
      if (k >= LAT) {rin, gin, bin} = tbl[(k - LAT) % FRAME];
      else          {rin, gin, bin} = 8'($urandom);
      #1;
      check_comb(ce_v);
      @(posedge clk);
      if (ce_v) k++;
      @(negedge clk);
   endtask

   task automatic check_reset_state();
      check_regs();
      chk("rst_xpos", 32'(xpos), 32'd0);
      chk("rst_ypos", 32'(ypos), 32'd0);
      chk("rst_line_start", 32'(line_start), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < FRAME; i++) tbl[i] = 8'($urandom);

      // Held in reset with ce high: strobes must stay low.
      ce = 1'b1;
      @(negedge clk);
      @(negedge clk);
      k = 0;
      check_reset_state();
      rst = 1'b0;

      // Continuous pixel ticks for just over two frames.
      for (int i = 0; i < 2 * FRAME + 20; i++) tick(1'b1);

      // ce every other clock.
      for (int i = 0; i < 2 * FRAME; i++) tick(i[0] == 1'b0);

      // Random ce gapping.
      for (int i = 0; i < 500; i++) tick($urandom_range(0, 2) != 0);

      // Asynchronous reset asserted between clock edges mid-frame.
      #3 rst = 1'b1;
      k = 0;
      #1 check_reset_state();
      @(negedge clk);
      check_reset_state();
      rst = 1'b0;

      // Restart: first tick shows origin and frame_start, then random ce.
      for (int i = 0; i < 600; i++) tick((i < 30) || ($urandom_range(0, 3) != 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 sync block.
- Sits between the pixel clock domain (clk plus pixel-tick enable) and the colour-generating logic (game/pattern modules).
- Produces pixel coordinates, registered sync pulses of configurable polarity, and frame/line strobes.
- Delays timing by a programmable pixel-pipeline latency so syncs, data-enable and blanked RGB leave aligned on the same output register.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width (ticks)
- H_BP, 48, horizontal back porch (ticks); H_TOTAL = sum of the four = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = 521
- H_POL, 0, hsync asserted level
- V_POL, 0, vsync asserted level
- CW, 11, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- RW/GW/BW, 3/3/2, red/green/blue channel widths
- PIX_LAT, 1, pixel-generator latency in ticks, legal 0..4

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-high reset
- ce, in, 1, pixel tick enable; all state advances only when ce=1
- rin, in, RW, red from pixel generator
- gin, in, GW, green from pixel generator
- bin, in, BW, blue from pixel generator
- xpos, out, CW, current horizontal count (hc)
- ypos, out, CW, current vertical count (vc)
- active, out, 1, hc<H_ACTIVE && vc<V_ACTIVE, undelayed
- line_start, out, 1, one-clk strobe when hc==0
- frame_start, out, 1, one-clk strobe when hc==0 && vc==0
- hsync, out, 1, registered, aligned to RGB
- vsync, out, 1, registered, aligned to RGB
- de, out, 1, registered data enable, aligned to RGB
- rout, out, RW, registered blanked red
- gout, out, GW, registered blanked green
- bout, out, BW, registered blanked blue

Behaviour:
- Reset (async, immediate):
  - hc=vc=0.
  - Delay line filled with inactive: de=0, syncs deasserted.
  - Outputs: hsync=~H_POL, vsync=~V_POL, de=0, rout/gout/bout=0, line_start=frame_start=0.
- Counters: on clk edge with ce=1:
  - hc wraps H_TOTAL-1 -> 0; otherwise increments.
  - vc increments only on hc wrap; vc wraps V_TOTAL-1 -> 0.
  - With ce=0 everything holds.
  - xpos/ypos equal hc/vc directly.
- Raw timing, combinational from counters:
  - h_act = hc<H_ACTIVE (strict; exactly H_ACTIVE pixels).
  - hs_raw asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (exactly H_SYNC ticks).
  - vs_raw asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; edges occur at hc==0.
- Strobes: line_start = ce && hc==0; frame_start = ce && hc==0 && vc==0. Never high when ce=0.
- Alignment contract:
  - Pixel generator sees xpos/ypos for pixel (x,y) at tick t and presents rin/gin/bin for that pixel at tick t+PIX_LAT.
  - {active, hs_raw, vs_raw} pass through a PIX_LAT-deep shift register advancing on ce. PIX_LAT=0 means direct.
  - On the same ce tick, the output register captures: de <= delayed active; hsync/vsync <= delayed raw syncs at polarity; rgb <= delayed active ? {rin,gin,bin} : 0.
  - Total latency from counter value to pins = PIX_LAT+1 ticks.
- Blanking: RGB outputs are exactly 0 whenever de=0, including porches, sync and vertical blank.
- Mid-operation reset: async clear to the reset values above; first tick after release shows hc=0, vc=0; frame_start asserted at that tick if ce=1.
- ce gapping: arbitrary ce patterns give the same tick-sequence on all outputs, stretched in clk time.
- Elaboration error if CW is too small or PIX_LAT>4.

Test Plan:
- Reset/defaults: assert rst mid-frame -> immediately hsync=1, vsync=1, de=0, rgb=0, xpos=ypos=0; after release with ce=1 every clk: frame_start high on first tick.
- Horizontal timing, defaults, ce=1: hsync low for exactly 96 ticks, falling edge at output PIX_LAT+1 ticks after xpos=656; line period 800 ticks; de high for exactly 640 ticks per visible line.
- Vertical timing: frame_start period = 416800 ticks; vsync low exactly 1600 ticks, starting when ypos=490,xpos=0 (plus PIX_LAT+1); de=0 for all lines 480..520.
- Alignment, PIX_LAT=2: generator drives rin=xpos[2:0] delayed 2 ticks -> at every de=1 tick, rout equals the x of the pixel; first visible rout=0, 640th=7; rout=0 at blanked ticks.
- ce=1 every other clk -> all periods double in clk cycles; line_start/frame_start stay single-clk pulses; counters hold on ce=0 cycles.
- Small config H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, H_POL=V_POL=1, PIX_LAT=0 -> hsync high exactly at xpos 5..6 (+1 tick); frame period 40 ticks; vsync high for 8 ticks.
